aes_ctr_sequencer: RTL and testbench

CTR-mode controller that sequences a single AESTop core to encrypt or decrypt a stream of 128-bit blocks.
- Loads key and initial counter block, then issues one AES operation per block on the counter value.
- XORs each keystream block with incoming plaintext and increments the counter between blocks.
- Sits between the system stream interfaces and the AES core, and owns the core's enable.

---
 rtl/aes_pkg.sv | 30 +++
 rtl/aes_ctr_watchdog.sv | 30 +++
 rtl/aes_ctr_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_aes_ctr_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES CTR-mode sequencer.
// Holds the FSM state encoding, datapath widths and the counter increment.
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    XOR   = 3'd2,
    OUT   = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } ctr_state_e;

  // Only the low 'width' bits count; the upper part of the block never changes.
  function automatic logic [BLOCK_W-1:0] ctr_inc(input logic [BLOCK_W-1:0] ctr,
                                                 input int unsigned width);
    logic [BLOCK_W-1:0] mask;
    if (width >= BLOCK_W) begin
      mask = {BLOCK_W{1'b1}};
    end else begin
      mask = (128'd1 << width) - 128'd1;
    end
    return (ctr & ~mask) | ((ctr + 128'd1) & mask);
  endfunction

endpackage

// File: rtl/aes_ctr_watchdog.sv
// Per-block watchdog: loaded on entry to key generation, counts down while running.
// expired is raised on the last permitted cycle so the FSM leaves after exactly TIMEOUT_CYCLES.
module aes_ctr_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  // Down-counter; load wins over run.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CW{1'b0}};
    end else if (load) begin
      count_q <= CW'(TIMEOUT_CYCLES - 1);
    end else if (run && (count_q != {CW{1'b0}})) begin
      count_q <= count_q - {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign expired = (count_q == {CW{1'b0}});

endmodule

// File: rtl/aes_ctr_sequencer.sv
// CTR-mode controller driving one AES core: generates keystream per counter block,
// XORs it with the input stream and steps the counter after each delivered block.
module aes_ctr_sequencer
  import aes_pkg::*;
#(
  parameter int CTR_WIDTH      = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [KEY_W-1:0]     key_i,
  input  logic [BLOCK_W-1:0]   iv_i,
  input  logic [LEN_WIDTH-1:0] num_blocks_i,
  input  logic                 pt_valid_i,
  output logic                 pt_ready_o,
  input  logic [BLOCK_W-1:0]   pt_data_i,
  output logic                 ct_valid_o,
  input  logic                 ct_ready_i,
  output logic [BLOCK_W-1:0]   ct_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 aes_en_o,
  output logic [BLOCK_W-1:0]   aes_block_o,
  output logic [KEY_W-1:0]     aes_key_o,
  input  logic [BLOCK_W-1:0]   aes_result_i,
  input  logic                 aes_done_i,
  input  logic                 aes_busy_i
);

  ctr_state_e state_q, state_d, nxt;

  logic [KEY_W-1:0]     key_q;
  logic [BLOCK_W-1:0]   ctr_q;
  logic [BLOCK_W-1:0]   ks_q;
  logic [BLOCK_W-1:0]   ct_q;
  logic [LEN_WIDTH-1:0] rem_q;

  logic pt_ready_q, ct_valid_q, busy_q, done_q, error_q, aes_en_q;
  logic wd_load, wd_run, wd_expired;

  // Core busy is status only and deliberately not part of any decision.
  logic unused_busy;
  assign unused_busy = aes_busy_i;

  aes_ctr_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .load    (wd_load),
    .run     (wd_run),
    .expired (wd_expired)
  );

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    nxt     = state_q;
    state_d = state_q;
    wd_load = 1'b0;
    wd_run  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          nxt = (num_blocks_i == {LEN_WIDTH{1'b0}}) ? DONE : GEN;
        end else begin
          nxt = IDLE;
        end
      end
      GEN: begin
        if (aes_done_i) begin
          nxt = XOR;
        end else if (wd_expired) begin
          nxt = ERROR;
        end else begin
          nxt = GEN;
        end
      end
      XOR: begin
        if (pt_valid_i) begin
          nxt = OUT;
        end else begin
          nxt = XOR;
        end
      end
      OUT: begin
        if (ct_ready_i) begin
          nxt = (rem_q == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) ? DONE : GAP;
        end else begin
          nxt = OUT;
        end
      end
      GAP:     nxt = GEN;
      DONE:    nxt = IDLE;
      ERROR:   nxt = ERROR;
      default: nxt = IDLE;
    endcase
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      state_d = nxt;
    end
    wd_run  = (state_q == GEN);
    wd_load = (state_d == GEN) && (state_q != GEN);
  end

  // State register and state-decoded output flags.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pt_ready_q <= 1'b0;
      ct_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      aes_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pt_ready_q <= (state_d == XOR);
      ct_valid_q <= (state_d == OUT);
      busy_q     <= (state_d == GEN) || (state_d == XOR) || (state_d == OUT) || (state_d == GAP);
      done_q     <= (state_d == DONE);
      error_q    <= (state_d == ERROR);
      aes_en_q   <= (state_d == GEN);
    end
  end

  // Job registers; an abort cycle must not latch, capture or advance anything.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= {KEY_W{1'b0}};
      ctr_q <= {BLOCK_W{1'b0}};
      ks_q  <= {BLOCK_W{1'b0}};
      ct_q  <= {BLOCK_W{1'b0}};
      rem_q <= {LEN_WIDTH{1'b0}};
    end else if (!abort_i) begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            key_q <= key_i;
            ctr_q <= iv_i;
            rem_q <= num_blocks_i;
          end
        end
        GEN: begin
          if (aes_done_i) begin
            ks_q <= aes_result_i;
          end
        end
        XOR: begin
          if (pt_valid_i) begin
            ct_q <= pt_data_i ^ ks_q;
          end
        end
        OUT: begin
          if (ct_ready_i) begin
            ctr_q <= ctr_inc(ctr_q, CTR_WIDTH);
            rem_q <= rem_q - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pt_ready_o  = pt_ready_q;
  assign ct_valid_o  = ct_valid_q;
  assign ct_data_o   = ct_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign aes_en_o    = aes_en_q;
  assign aes_block_o = ctr_q;
  assign aes_key_o   = key_q;

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Self-checking bench for aes_ctr_sequencer with a behavioural AES core stand-in
// and a queue scoreboard of expected counter blocks and result blocks.
module tb_aes_ctr_sequencer;

  localparam int LAT     = 3;
  localparam int TIMEOUT = 1023;

  logic         clk_i = 1'b0;
  logic         rst_n;
  logic         start_i, abort_i;
  logic [255:0] key_i;
  logic [127:0] iv_i;
  logic [15:0]  num_blocks_i;
  logic         pt_valid_i, pt_ready_o;
  logic [127:0] pt_data_i;
  logic         ct_valid_o, ct_ready_i;
  logic [127:0] ct_data_o;
  logic         busy_o, done_o, error_o, aes_en_o;
  logic [127:0] aes_block_o;
  logic [255:0] aes_key_o;
  logic [127:0] aes_result_i;
  logic         aes_done_i, aes_busy_i;

  int n_checks = 0;
  int n_errors = 0;
  bit stub_core = 1'b0;
  int lat_cnt;
  logic [255:0] cur_key;
  logic [127:0] exp_blk[$];
  logic [127:0] exp_ct[$];

  always #5 clk_i = ~clk_i;

  aes_ctr_sequencer dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .key_i(key_i), .iv_i(iv_i), .num_blocks_i(num_blocks_i),
    .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_o), .pt_data_i(pt_data_i),
    .ct_valid_o(ct_valid_o), .ct_ready_i(ct_ready_i), .ct_data_o(ct_data_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .aes_en_o(aes_en_o), .aes_block_o(aes_block_o), .aes_key_o(aes_key_o),
    .aes_result_i(aes_result_i), .aes_done_i(aes_done_i), .aes_busy_i(aes_busy_i)
  );

  function automatic logic [127:0] model_ks(input logic [127:0] blk, input logic [255:0] key);
    return {blk[60:0], blk[127:61]} ^ key[255:128] ^ key[127:0];
  endfunction

  function automatic logic [127:0] blk_at(input logic [127:0] iv, input int i);
    return {iv[127:32], iv[31:0] + 32'(i)};
  endfunction

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural core: done pulses after LAT enabled cycles unless stubbed.
  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt      <= 0;
      aes_done_i   <= 1'b0;
      aes_result_i <= 128'd0;
    end else begin
      aes_done_i <= 1'b0;
      if (aes_en_o && !stub_core) begin
        if (lat_cnt == LAT - 1) begin
          aes_done_i   <= 1'b1;
          aes_result_i <= model_ks(aes_block_o, aes_key_o);
          lat_cnt      <= 0;
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end else begin
        lat_cnt <= 0;
      end
    end
  end
  assign aes_busy_i = aes_en_o;

  // Handshake and enable outputs must be mutually exclusive.
  always @(negedge clk_i) begin
    if (rst_n) check_eq("excl", 256'($onehot0({pt_ready_o, ct_valid_o, aes_en_o})), 256'd1);
  end

  task automatic start_job(input logic [255:0] key, input logic [127:0] iv, input int n);
    @(negedge clk_i);
    key_i = key; iv_i = iv; num_blocks_i = 16'(n); start_i = 1'b1;
    cur_key = key;
    for (int i = 0; i < n; i++) exp_blk.push_back(blk_at(iv, i));
    @(negedge clk_i);
    start_i = 1'b0;
    check_eq("busy_start", busy_o, 256'(n != 0));
  endtask

  task automatic do_block(input logic [127:0] pt, input int hold, input bit last);
    int cyc;
    logic [127:0] blk;
    cyc = 0;
    while (!aes_en_o && cyc < 50) begin @(negedge clk_i); cyc++; end
    check_eq("gen_seen", aes_en_o, 256'd1);
    blk = exp_blk.pop_front();
    check_eq("aes_block", aes_block_o, blk);
    check_eq("aes_key", aes_key_o, cur_key);
    pt_valid_i = 1'b1; pt_data_i = pt;
    exp_ct.push_back(pt ^ model_ks(blk, cur_key));
    cyc = 0;
    while (!ct_valid_o && cyc < 50) begin @(negedge clk_i); cyc++; end
    check_eq("latency", 256'(cyc), 256'(LAT + 2));
    pt_valid_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      check_eq("hold_valid", ct_valid_o, 256'd1);
      check_eq("hold_data", ct_data_o, exp_ct[0]);
      check_eq("hold_ctr", aes_block_o, blk);
      @(negedge clk_i);
    end
    ct_ready_i = 1'b1;
    check_eq("ct_data", ct_data_o, exp_ct.pop_front());
    @(negedge clk_i);
    ct_ready_i = 1'b0;
    check_eq("post_valid", ct_valid_o, 256'd0);
    check_eq("post_en", aes_en_o, 256'd0);
    check_eq("done_at_hs", done_o, 256'(last));
    check_eq("ctr_inc", aes_block_o, {blk[127:32], blk[31:0] + 32'd1});
    if (!last) begin
      @(negedge clk_i);
      check_eq("gap_one", aes_en_o, 256'd1);
    end else begin
      check_eq("busy_done", busy_o, 256'd0);
      @(negedge clk_i);
      check_eq("done_pulse", done_o, 256'd0);
      check_eq("busy_after", busy_o, 256'd0);
    end
  endtask

  task automatic run_job(input logic [255:0] key, input logic [127:0] iv, input int n,
                         input int hold_first, input bit zero_pt);
    logic [127:0] pt;
    start_job(key, iv, n);
    for (int i = 0; i < n; i++) begin
      pt = zero_pt ? 128'd0 : {$urandom(), $urandom(), $urandom(), $urandom()};
      do_block(pt, (i == 0) ? hold_first : 0, i == n - 1);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq(tag, {pt_ready_o, ct_valid_o, busy_o, done_o, error_o, aes_en_o,
                   (ct_data_o != 128'd0), (aes_block_o != 128'd0), (aes_key_o != 256'd0)}, 256'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; key_i = '0; iv_i = '0;
    num_blocks_i = '0; pt_valid_i = 1'b0; pt_data_i = '0; ct_ready_i = 1'b0;
    cur_key = '0;
    repeat (3) @(negedge clk_i);
    check_quiet("reset_outputs");
    rst_n = 1'b1;

    run_job(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
            128'h00112233445566778899aabbccddeeff, 1, 0, 1'b1);
    run_job(256'hdeadbeef_01234567_89abcdef_0badf00d_cafebabe_11223344_55667788_99aabbcc,
            128'h0123456789abcdef01234567fffffffe, 3, 0, 1'b0);
    run_job({8{$urandom()}}, 128'h55555555aaaaaaaa5555555500000010, 2, 5, 1'b0);

    // Zero-length job goes straight to DONE.
    start_job(256'h1, 128'h2, 0);
    check_eq("zero_done", done_o, 256'd1);
    check_eq("zero_en", aes_en_o, 256'd0);
    @(negedge clk_i);
    check_eq("zero_done_end", done_o, 256'd0);

    // Core that never finishes trips the watchdog.
    stub_core = 1'b1;
    start_job(256'h77, 128'h88, 1);
    exp_blk.delete();
    cyc = 0;
    while (aes_en_o && cyc < 2000) begin @(negedge clk_i); cyc++; end
    check_eq("timeout_cycles", 256'(cyc), 256'(TIMEOUT));
    check_eq("error_set", error_o, 256'd1);
    check_eq("error_busy", busy_o, 256'd0);
    repeat (3) @(negedge clk_i);
    check_eq("error_sticky", {error_o, aes_en_o}, 256'd2);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check_eq("abort_clears_err", error_o, 256'd0);
    stub_core = 1'b0;

    // Reset in the middle of key generation.
    start_job(256'h99, 128'haa, 4);
    exp_blk.delete();
    check_eq("rst_in_gen", aes_en_o, 256'd1);
    rst_n = 1'b0;
    #1;
    check_quiet("rst_async");
    @(negedge clk_i);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin @(negedge clk_i); check_eq("rst_no_done", done_o, 256'd0); end
    run_job({8{$urandom()}}, 128'h1000, 2, 0, 1'b0);

    // Abort while waiting for input data.
    start_job(256'h5a5a, 128'hffff, 2);
    exp_blk.delete();
    cyc = 0;
    while (!pt_ready_o && cyc < 50) begin @(negedge clk_i); cyc++; end
    check_eq("xor_reached", pt_ready_o, 256'd1);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check_eq("abort_drop", {pt_ready_o, ct_valid_o, busy_o, aes_en_o}, 256'd0);
    for (int i = 0; i < 4; i++) begin @(negedge clk_i); check_eq("abort_no_done", done_o, 256'd0); end
    run_job({8{$urandom()}}, 128'hfffffffffffffffffffffffffffffffe, 2, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
